// File: rtl/powlib_mcswissfifo.sv
// powlib_mcswissfifo
// Single-clock multi-channel FIFO: C independent queues of depth D share one
// storage array addressed as {channel, pointer}. One channel-addressed write
// port and one channel-addressed read port; per-channel count, empty, full,
// almost-full and sticky overflow/underflow flags.
//
// Ports:
//   clk, rstn        clock (rising edge), asynchronous active-low reset
//   wrvld/wrch/wrdata  write request, target channel, data
//   rdreq/rdch         read request, source channel
//   rdvld/rddata/rdchout  registered read result (one cycle after acceptance)
//   empty/full/afull   per-channel status decoded from the registered count
//   cnt                per-channel fill count, channel c at [c*(LD+1) +: LD+1]
//   ovf/udf            sticky: write rejected on full / read rejected on empty
//
// Handshake: there is no ready signal. A request is accepted in the cycle it
// is presented if the addressed channel can take it (write: not full, read:
// not empty, channel < C), judged on status registered at the previous edge.
// Rejected requests are dropped and only raise the sticky flag. rdvld pulses
// for exactly one cycle per accepted read and must be consumed that cycle.
module powlib_mcswissfifo #(
    parameter int W   = 32,
    parameter int D   = 16,
    parameter int C   = 4,
    parameter int AFT = 14,
    localparam int LD = $clog2(D),
    localparam int CW = (C > 1) ? $clog2(C) : 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  wrvld,
    input  logic [CW-1:0]         wrch,
    input  logic [W-1:0]          wrdata,
    input  logic                  rdreq,
    input  logic [CW-1:0]         rdch,
    output logic                  rdvld,
    output logic [W-1:0]          rddata,
    output logic [CW-1:0]         rdchout,
    output logic [C-1:0]          empty,
    output logic [C-1:0]          full,
    output logic [C-1:0]          afull,
    output logic [C*(LD+1)-1:0]   cnt,
    output logic [C-1:0]          ovf,
    output logic [C-1:0]          udf
);

    localparam logic [CW:0] C_LIM   = (CW+1)'(C);
    localparam logic [LD:0] D_CNT   = (LD+1)'(D);
    localparam logic [LD:0] AFT_CNT = (LD+1)'(AFT);

    logic [W-1:0]    mem [C*D];

    logic [LD-1:0]   wp_q  [C];
    logic [LD-1:0]   wp_d  [C];
    logic [LD-1:0]   rp_q  [C];
    logic [LD-1:0]   rp_d  [C];
    logic [LD:0]     cnt_q [C];
    logic [LD:0]     cnt_d [C];
    logic [C-1:0]    ovf_q, ovf_d;
    logic [C-1:0]    udf_q, udf_d;
    logic            rdvld_q, rdvld_d;
    logic [W-1:0]    rddata_q, rddata_d;
    logic [CW-1:0]   rdchout_q, rdchout_d;

    logic            wr_inrange, rd_inrange;
    logic            wa, ra;
    logic            wr_c, rd_c;
    logic [CW+LD-1:0] wr_addr, rd_addr;

    // Status comes only from the registered counts, so a write this cycle
    // never makes data readable (or space writable) in the same cycle.
    always_comb begin
        empty = '0;
        full  = '0;
        afull = '0;
        cnt   = '0;
        for (int c = 0; c < C; c++) begin
            empty[c]                 = (cnt_q[c] == '0);
            full[c]                  = (cnt_q[c] == D_CNT);
            afull[c]                 = (cnt_q[c] >= AFT_CNT);
            cnt[c*(LD+1) +: (LD+1)]  = cnt_q[c];
        end
    end

    // Out-of-range channels are ignored outright, without touching the flags.
    assign wr_inrange = ({1'b0, wrch} < C_LIM);
    assign rd_inrange = ({1'b0, rdch} < C_LIM);
    assign wa         = wrvld & wr_inrange & ~full[wrch];
    assign ra         = rdreq & rd_inrange & ~empty[rdch];
    assign wr_addr    = {wrch, wp_q[wrch]};
    assign rd_addr    = {rdch, rp_q[rdch]};

    always_comb begin
        wp_d      = wp_q;
        rp_d      = rp_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        udf_d     = udf_q;
        rdvld_d   = ra;
        rddata_d  = rddata_q;
        rdchout_d = rdchout_q;
        wr_c      = 1'b0;
        rd_c      = 1'b0;

        if (wrvld && wr_inrange && full[wrch]) ovf_d[wrch] = 1'b1;
        if (rdreq && rd_inrange && empty[rdch]) udf_d[rdch] = 1'b1;

        if (ra) begin
            rddata_d  = mem[rd_addr];
            rdchout_d = rdch;
        end

        for (int c = 0; c < C; c++) begin
            wr_c = wa && (wrch == CW'(c));
            rd_c = ra && (rdch == CW'(c));
            if (wr_c) wp_d[c] = wp_q[c] + 1'b1;
            if (rd_c) rp_d[c] = rp_q[c] + 1'b1;
            // Simultaneous accepted write and read on one channel cancel out.
            case ({wr_c, rd_c})
                2'b10:   cnt_d[c] = cnt_q[c] + 1'b1;
                2'b01:   cnt_d[c] = cnt_q[c] - 1'b1;
                default: cnt_d[c] = cnt_q[c];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int c = 0; c < C; c++) begin
                wp_q[c]  <= '0;
                rp_q[c]  <= '0;
                cnt_q[c] <= '0;
            end
            ovf_q     <= '0;
            udf_q     <= '0;
            rdvld_q   <= 1'b0;
            rddata_q  <= '0;
            rdchout_q <= '0;
        end else begin
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
            rdvld_q   <= rdvld_d;
            rddata_q  <= rddata_d;
            rdchout_q <= rdchout_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wa) mem[wr_addr] <= wrdata;
    end

    assign rdvld   = rdvld_q;
    assign rddata  = rddata_q;
    assign rdchout = rdchout_q;
    assign ovf     = ovf_q;
    assign udf     = udf_q;

endmodule
